// File: rtl/uart_pkg.sv
// Shared UART definitions used by rx_uart and tx_uart.
// Contents:
//   - FSM state codes (IDLE, START, DATA, STOP, BREAK)
//   - frame geometry (DATA_BITS)
//   - default baud timing (DEFAULT_CLOCKS_PER_BAUD, DEFAULT_TIMER_BITS)
//   - maj3(): 2-of-3 majority vote used by the optional oversampled receiver
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam int DATA_BITS = 8;

  // 868 clocks per bit is 115200 baud from a 100 MHz clock.
  localparam int DEFAULT_CLOCKS_PER_BAUD = 868;
  localparam int DEFAULT_TIMER_BITS      = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clk_i cycles of latency)
// RESET_VAL lets the caller preload the inactive level of the line so that
// releasing reset does not create a spurious edge downstream.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/rx_uart.sv
// UART receiver, 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit,
// line idles high). Each good frame produces a one-cycle o_valid pulse
// with the byte on o_data; a low stop bit produces a one-cycle o_frame_err
// pulse and the receiver then waits for the line to return high.
// Ports:
//   clk          - system clock, all logic on posedge
//   i_reset      - synchronous active-high reset
//   uart_txd_in  - asynchronous serial line, idle high
//   o_data       - received byte, held between frames
//   o_valid      - one-cycle pulse per good frame
//   o_frame_err  - one-cycle pulse when the stop bit samples low
//   o_busy       - high whenever the receiver is not idle
// Build option:
//   RX_MAJORITY_EN - when defined, every bit decision is a 2-of-3 vote of
//   samples taken at timer = 1, timer = 0 and one cycle after expiry; the
//   decision (and state change) lands one cycle later. Needs
//   CLOCKS_PER_BAUD >= 8. Default build samples once at timer expiry.
module rx_uart
  import uart_pkg::*;
#(
  parameter int TIMER_BITS      = DEFAULT_TIMER_BITS,
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 uart_txd_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam logic [TIMER_BITS-1:0] HALF_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
`ifdef RX_MAJORITY_EN
  // The decision cycle itself consumes one clock of the bit period.
  localparam logic [TIMER_BITS-1:0] BIT_RELOAD  = TIMER_BITS'(CLOCKS_PER_BAUD - 2);
`else
  localparam logic [TIMER_BITS-1:0] BIT_RELOAD  = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
`endif
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                  rx_s;
  logic                  rx_prev_q;
  logic [2:0]            state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  timer_zero;
  logic                  fall;
  logic                  tick;
  logic                  bit_val;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk),
    .rst_i (i_reset),
    .d_i   (uart_txd_in),
    .q_o   (rx_s)
  );

  assign timer_zero = (timer_q == '0);
  assign fall       = rx_prev_q & ~rx_s;

`ifdef RX_MAJORITY_EN
  logic pend_q, pend_d;
  logic s1_q, s1_d;
  logic s0_q, s0_d;

  // pend_q marks the cycle after expiry, where the third sample is rx_s itself.
  assign tick    = pend_q;
  assign bit_val = maj3(s1_q, s0_q, rx_s);

  always_comb begin
    pend_d = timer_zero && !pend_q &&
             (state_q == START || state_q == DATA || state_q == STOP);
    s1_d   = (timer_q == TIMER_BITS'(1)) ? rx_s : s1_q;
    s0_d   = (timer_zero && !pend_q) ? rx_s : s0_q;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      pend_q <= 1'b0;
      s1_q   <= 1'b1;
      s0_q   <= 1'b1;
    end else begin
      pend_q <= pend_d;
      s1_q   <= s1_d;
      s0_q   <= s0_d;
    end
  end
`else
  assign tick    = timer_zero;
  assign bit_val = rx_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      rx_prev_q <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rx_prev_q <= rx_s;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_zero ? timer_q : timer_q - TIMER_BITS'(1);
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          timer_d = HALF_RELOAD;
        end
      end
      START: begin
        if (tick) begin
          if (bit_val) begin
            state_d = IDLE;          // line back high at mid start bit: glitch
          end else begin
            state_d  = DATA;
            timer_d  = BIT_RELOAD;
            bitcnt_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d  = {bit_val, shift_q[DATA_BITS-1:1]};
          timer_d  = BIT_RELOAD;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit gives zero dead time before the next start edge.
        if (tick) begin
          state_d = bit_val ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    data_d  = data_q;
    if (state_q == STOP && tick) begin
      if (bit_val) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
module tb_rx_uart;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       uart_txd_in;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  always #5 clk = ~clk;

  rx_uart #(.TIMER_BITS(32), .CLOCKS_PER_BAUD(CPB)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .uart_txd_in (uart_txd_in),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  int          ferr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect every received byte with its cycle stamp.
  always @(negedge clk) begin
    if (o_valid) begin
      got_q.push_back(o_data);
      got_t.push_back(cyc);
    end
    if (o_frame_err) ferr_cnt++;
  end

  // Loopback transmitter model: re-serialises every received byte as 8N1.
  logic       uart_rxd_out = 1'b1;
  logic       lb_active = 1'b0;
  logic [8:0] lb_sh = '0;
  int         lb_bits = 0;
  int         lb_cnt = 0;

  always @(posedge clk) begin
    if (!lb_active) begin
      uart_rxd_out <= 1'b1;
      if (o_valid) begin
        lb_active    <= 1'b1;
        uart_rxd_out <= 1'b0;
        lb_sh        <= {1'b1, o_data};
        lb_bits      <= 9;
        lb_cnt       <= CPB - 1;
      end
    end else if (lb_cnt != 0) begin
      lb_cnt <= lb_cnt - 1;
    end else if (lb_bits == 0) begin
      lb_active <= 1'b0;
    end else begin
      uart_rxd_out <= lb_sh[0];
      lb_sh        <= lb_sh >> 1;
      lb_bits      <= lb_bits - 1;
      lb_cnt       <= CPB - 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_txd_in = v;
    wait_cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    uart_txd_in = 1'b1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    ferr_cnt = 0;
  endtask

  task automatic test_reset();
    uart_txd_in = 1'b1;
    i_reset = 1'b1;
    wait_cyc(3);
    i_reset = 1'b0;
    wait_cyc(1);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_o_data: got %h expected 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_o_frame_err: got %b expected 0", o_frame_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_o_busy: got %b expected 0", o_busy); end
    wait_cyc(20);
  endtask

  task automatic test_single();
    clear_mon();
    send_byte(8'hA5, 1'b1);
    wait_cyc(20);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    int unsigned gap;
    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_cyc(20);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (got_q.size() < 2 || got_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", (got_q.size() > 1) ? got_q[1] : 8'hxx); end
    gap = (got_t.size() >= 2) ? got_t[1] - got_t[0] : 0;
    checks++; if (gap < 10 * CPB - 1 || gap > 10 * CPB + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d +-1", gap, 10 * CPB); end
  endtask

  task automatic test_glitch();
    clear_mon();
    uart_txd_in = 1'b0;
    wait_cyc(4);
    uart_txd_in = 1'b1;
    wait_cyc(10);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy %b expected 0", o_busy); end
    wait_cyc(3 * CPB);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", got_q.size()); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    clear_mon();
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    uart_txd_in = 1'b0;
    wait_cyc(40);
    uart_txd_in = 1'b1;
    wait_cyc(2 * CPB);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", got_q.size()); end
    clear_mon();
    send_byte(8'h55, 1'b1);
    wait_cyc(20);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h55) begin errors++; $display("FAIL ferr_recover: got count %0d data %h expected 1 55", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_mon();
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_txd_in = b[4];
    wait_cyc(CPB / 2);
    i_reset = 1'b1;
    uart_txd_in = 1'b1;
    wait_cyc(2);
    i_reset = 1'b0;
    wait_cyc(1);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", o_data); end
    wait_cyc(12 * CPB);
    checks++; if (got_q.size() != 0 || ferr_cnt != 0) begin errors++; $display("FAIL midrst_outputs: got valid %0d ferr %0d expected 0 0", got_q.size(), ferr_cnt); end
    send_byte(8'h81, 1'b1);
    wait_cyc(20);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL midrst_next: got count %0d data %h expected 1 81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    clear_mon();
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      wait_cyc($urandom_range(0, 30));
    end
    wait_cyc(20);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size(); n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL random_byte%0d: got %h expected %h", n, (n < got_q.size()) ? got_q[n] : 8'hxx, exp_q[n]);
      end
    end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL random_ferr: got %0d expected 0", ferr_cnt); end
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    logic [9:0] seen;
    bit         found;
    clear_mon();
    b = 8'h4B;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    uart_txd_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      wait_cyc(1);
      if (uart_rxd_out === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL loopback_start: no start bit on uart_rxd_out within 100 cycles");
    end else begin
      wait_cyc(CPB / 2);
      for (int i = 0; i < 10; i++) begin
        seen[i] = uart_rxd_out;
        wait_cyc(CPB);
      end
      checks++;
      if (seen !== {1'b1, b, 1'b0}) begin
        errors++;
        $display("FAIL loopback_frame: got %b expected %b", seen, {1'b1, b, 1'b0});
      end
    end
    wait_cyc(2 * CPB);
  endtask

  initial begin
    i_reset = 1'b1;
    uart_txd_in = 1'b1;
    wait_cyc(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_random();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
